// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select of a 4:1 one-bit mux, with a bounded hold time.
// Optional lock input that extends a grant past expiry is enabled by defining MUX_ARB_LOCK_EN.
module mux_rr_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] x,
`ifdef MUX_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       y
);

  localparam int unsigned CntW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(HOLD_CYCLES - 1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e          state_q;
  logic [1:0]      ptr_q;
  logic [CntW-1:0] cnt_q;

  logic       lock_act;
  logic       idle_found;
  logic [1:0] idle_pick;
  logic [1:0] idle_idx;
  logic       rel_found;
  logic [1:0] rel_pick;
  logic [1:0] rel_idx;
  logic       expired;
  logic       rel_now;

`ifdef MUX_ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // Full search from ptr+1 through ptr; walking backwards leaves the first hit in RR order.
  always_comb begin
    idle_found = 1'b0;
    idle_pick  = ptr_q;
    idle_idx   = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      idle_idx = ptr_q + 2'(k);
      if (req[idle_idx]) begin
        idle_found = 1'b1;
        idle_pick  = idle_idx;
      end
    end
  end

  // Release search excludes the current owner.
  always_comb begin
    rel_found = 1'b0;
    rel_pick  = sel;
    rel_idx   = sel;
    for (int k = 3; k >= 1; k--) begin
      rel_idx = sel + 2'(k);
      if (req[rel_idx]) begin
        rel_found = 1'b1;
        rel_pick  = rel_idx;
      end
    end
  end

  assign expired = (cnt_q == CntMax) && !lock_act;
  assign rel_now = !req[sel] || expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt     <= 4'b0000;
      sel     <= 2'd0;
      valid   <= 1'b0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (idle_found) begin
            state_q <= StGrant;
            gnt     <= 4'b0001 << idle_pick;
            sel     <= idle_pick;
            ptr_q   <= idle_pick;
            valid   <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StGrant: begin
          if (rel_now) begin
            if (rel_found) begin
              gnt   <= 4'b0001 << rel_pick;
              sel   <= rel_pick;
              ptr_q <= rel_pick;
              cnt_q <= '0;
            end else if (req[sel]) begin
              cnt_q <= '0;
            end else begin
              state_q <= StIdle;
              gnt     <= 4'b0000;
              valid   <= 1'b0;
            end
          end else if (cnt_q != CntMax) begin
            // Saturates at CntMax while lock holds the grant.
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign y = x[sel] & valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a driver pushes model predictions, a monitor compares them.
// Define MUX_ARB_LOCK_EN to exercise the lock input as well.
module tb_mux_rr_arbiter;

  localparam int unsigned HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic [3:0] req;
  logic [3:0] x;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       y;

  mux_rr_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .x     (x),
`ifdef MUX_ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .y     (y)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: owner (-1 when idle), last granted index, cycles held so far.
  int owner = -1;
  int last  = 3;
  int held  = 0;
  int sel_m = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic model_step(input bit r, input logic [3:0] rq, input bit lk);
    exp_t e;
    int   found;
    if (r) begin
      owner = -1;
      last  = 3;
      held  = 0;
      sel_m = 0;
    end else if (owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (owner < 0 && rq[(last + k) % 4]) begin
          owner = (last + k) % 4;
          last  = owner;
          sel_m = owner;
          held  = 1;
        end
      end
    end else if (!rq[owner] || (held >= HOLD && !lk)) begin
      found = -1;
      for (int k = 1; k <= 3; k++) begin
        if (found < 0 && rq[(owner + k) % 4]) found = (owner + k) % 4;
      end
      if (found >= 0) begin
        owner = found;
        last  = found;
        sel_m = found;
        held  = 1;
      end else if (rq[owner]) begin
        held = 1;
      end else begin
        owner = -1;
      end
    end else begin
      held++;
    end
    e.gnt   = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
    e.sel   = 2'(sel_m);
    e.valid = (owner >= 0);
    exp_q.push_back(e);
  endtask

  // Inputs are applied just after an edge; the next edge samples them and the model predicts it.
  task automatic tick(input bit r, input logic [3:0] rq, input logic [3:0] xv, input bit lk);
    rst  = r;
    req  = rq;
    x    = xv;
    lock = lk;
    @(posedge clk);
    model_step(r, rq, lk);
    #1;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [3:0] xv;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        xv = x;
        check("gnt", 8'(gnt), 8'(e.gnt));
        check("sel", 8'(sel), 8'(e.sel));
        check("valid", 8'(valid), 8'(e.valid));
        check("y", 8'(y), 8'(xv[e.sel] & e.valid));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [3:0] rq;
    bit         lk;
    rst  = 1'b1;
    req  = 4'b0000;
    x    = 4'b0000;
    lock = 1'b0;
    repeat (2) tick(1'b1, 4'b0000, 4'b0000, 1'b0);

    // Single requester: grant after one edge, re-granted at expiry without a gap.
    repeat (10) tick(1'b0, 4'b0001, 4'b0001, 1'b0);

    // All requesting: rotation with HOLD cycles each.
    repeat (20) tick(1'b0, 4'b1111, 4'($urandom), 1'b0);

    // Requester 0 drops mid-grant; requester 2 takes over, its data toggling onto y.
    tick(1'b1, 4'b0000, 4'b0000, 1'b0);
    repeat (3) tick(1'b0, 4'b0101, 4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 4'b0100, (i % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0);

    // Reset during a grant to requester 2, then all request.
    tick(1'b1, 4'b0100, 4'b0100, 1'b0);
    repeat (6) tick(1'b0, 4'b1111, 4'($urandom), 1'b0);

`ifdef MUX_ARB_LOCK_EN
    tick(1'b1, 4'b0000, 4'b0000, 1'b0);
    repeat (12) tick(1'b0, 4'b0011, 4'($urandom), 1'b1);
    repeat (4) tick(1'b0, 4'b0011, 4'($urandom), 1'b0);
`endif

    rq = 4'b0000;
    lk = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
`ifdef MUX_ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) lk = ~lk;
`endif
      tick(($urandom_range(0, 63) == 0), rq, 4'($urandom), lk);
    end

    repeat (2) tick(1'b0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    #1;
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
